// File: rtl/vga_plot_queue.sv
// Plot-request FIFO between the MMU VGA window and the VGA adapter, with an
// ordered full-screen clear sweep that is emitted through the same handshake.
module vga_plot_queue #(
  parameter int          DEPTH       = 8,
  parameter int          SCREEN_W    = 320,
  parameter int          SCREEN_H    = 240,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_plot,
  input  logic [8:0]                 in_x,
  input  logic [7:0]                 in_y,
  input  logic [23:0]                in_color,
  input  logic                       clear_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8:0]                 out_x,
  output logic [7:0]                 out_y,
  output logic [23:0]                out_color,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       busy,
  output logic                       overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [8:0]    X_LAST   = 9'(SCREEN_W - 1);
  localparam logic [7:0]    Y_LAST   = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t        state;
  logic [40:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pending;
  logic [LW-1:0] clear_after;
  logic [8:0]    cx;
  logic [7:0]    cy;

  logic clear_ready;
  logic xfer;
  logic pop;
  logic push;

  // A pending clear with nothing ahead of it blocks further pops; this is the bubble.
  assign clear_ready = pending && (clear_after == '0);
  assign xfer        = out_valid && out_ready;
  assign pop         = xfer && (state == DRAIN);
  assign push        = in_plot && ((level != LVL_FULL) || pop);

  assign full = (level == LVL_FULL);
  assign busy = (state != IDLE) || pending;

  always_comb begin
    out_valid = 1'b0;
    out_x     = '0;
    out_y     = '0;
    out_color = '0;
    case (state)
      DRAIN: begin
        out_valid                   = (level != '0) && !clear_ready;
        {out_x, out_y, out_color}   = mem[rd_ptr];
      end
      CLEAR: begin
        out_valid = 1'b1;
        out_x     = cx;
        out_y     = cy;
        out_color = CLEAR_COLOR;
      end
      default: ;
    endcase
  end

  // Entry storage carries no reset; only the pointers and level qualify it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_color};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      pending     <= 1'b0;
      clear_after <= '0;
      cx          <= '0;
      cy          <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
      if (in_plot && !push) overflow <= 1'b1;

      // clear_after counts entries that must leave before the sweep may start.
      if (clear_req && !pending && (state != CLEAR)) begin
        pending     <= 1'b1;
        clear_after <= level - LW'(pop);
      end else if (pending && pop && (clear_after != '0)) begin
        clear_after <= clear_after - LW'(1);
      end

      case (state)
        IDLE: begin
          if (clear_ready) begin
            state   <= CLEAR;
            pending <= 1'b0;
            cx      <= '0;
            cy      <= '0;
          end else if ((level != '0) || push) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (clear_ready) begin
            state   <= CLEAR;
            pending <= 1'b0;
            cx      <= '0;
            cy      <= '0;
          end else if ((level == '0) && !push) begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (xfer) begin
            if (cx == X_LAST) begin
              cx <= '0;
              if (cy == Y_LAST) begin
                cy    <= '0;
                state <= (level != '0) ? DRAIN : IDLE;
              end else begin
                cy <= cy + 8'd1;
              end
            end else begin
              cx <= cx + 9'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_queue.sv
// Bench for vga_plot_queue: directed scenarios plus a randomized run checked
// against an ordered pixel-stream model. A reduced screen keeps sweeps short.
module tb_vga_plot_queue;

  localparam int          DEPTH = 8;
  localparam int          W     = 20;
  localparam int          H     = 8;
  localparam int          LW    = $clog2(DEPTH + 1);
  localparam logic [23:0] CC    = 24'hA5C33C;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_plot;
  logic [8:0]    in_x;
  logic [7:0]    in_y;
  logic [23:0]   in_color;
  logic          clear_req;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    out_x;
  logic [7:0]    out_y;
  logic [23:0]   out_color;
  logic [LW-1:0] level;
  logic          full;
  logic          busy;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [23:0] c;
    bit          clr;
  } item_t;
  item_t expq[$];

  vga_plot_queue #(.DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .reset_n(reset_n), .in_plot(in_plot), .in_x(in_x), .in_y(in_y),
    .in_color(in_color), .clear_req(clear_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .level(level), .full(full), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_plot = 1'b0; clear_req = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_color = '0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic push_one(input logic [8:0] x, input logic [7:0] y, input logic [23:0] c);
    in_plot = 1'b1; in_x = x; in_y = y; in_color = c;
    tick();
    in_plot = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 9; i++) push_one(9'(i), 8'(i), 24'(i));
    reset_n = 1'b0;
    tick();
    total++;
    if ({out_valid, out_x, out_y, out_color, level, full, busy, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0",
               {out_valid, out_x, out_y, out_color, level, full, busy, overflow});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    in_plot = 1'b1; in_x = 9'd10; in_y = 8'd20; in_color = 24'hFF0000;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b exp=0", out_valid); end
    tick();
    in_x = 9'd11; in_color = 24'h00FF00;
    total++;
    if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'd10, 8'd20, 24'hFF0000}) begin
      bad++; $display("FAIL basic_px1 got=%h exp=%h", {out_valid, out_x, out_y, out_color},
                      {1'b1, 9'd10, 8'd20, 24'hFF0000});
    end
    tick();
    in_plot = 1'b0;
    total++;
    if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'd11, 8'd20, 24'h00FF00}) begin
      bad++; $display("FAIL basic_px2 got=%h exp=%h", {out_valid, out_x, out_y, out_color},
                      {1'b1, 9'd11, 8'd20, 24'h00FF00});
    end
    tick();
    total++;
    if ({out_valid, level} !== '0) begin
      bad++; $display("FAIL basic_empty got=%h exp=0", {out_valid, level});
    end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) push_one(9'(100 + i), 8'(i), 24'(i * 111));
    total++;
    if ({full, level, overflow} !== {1'b1, LW'(8), 1'b1}) begin
      bad++; $display("FAIL ovf_flags got=%h exp=%h", {full, level, overflow}, {1'b1, LW'(8), 1'b1});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'(100 + i), 8'(i), 24'(i * 111)}) begin
        bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, {out_valid, out_x, out_y, out_color},
                        {1'b1, 9'(100 + i), 8'(i), 24'(i * 111)});
      end
      tick();
    end
    total++;
    if ({out_valid, level, overflow} !== {1'b0, LW'(0), 1'b1}) begin
      bad++; $display("FAIL ovf_after got=%h exp=%h", {out_valid, level, overflow}, {1'b0, LW'(0), 1'b1});
    end
  endtask

  task automatic test_pushpop_full();
    do_reset();
    for (int i = 0; i < 8; i++) push_one(9'(200 + i), 8'd3, 24'(i));
    out_ready = 1'b1;
    in_plot = 1'b1; in_x = 9'd300; in_y = 8'd77; in_color = 24'hABCDEF;
    total++;
    if ({out_valid, out_x, level} !== {1'b1, 9'd200, LW'(8)}) begin
      bad++; $display("FAIL pp_head got=%h exp=%h", {out_valid, out_x, level}, {1'b1, 9'd200, LW'(8)});
    end
    tick();
    in_plot = 1'b0;
    total++;
    if ({level, overflow} !== {LW'(8), 1'b0}) begin
      bad++; $display("FAIL pp_level got=%h exp=%h", {level, overflow}, {LW'(8), 1'b0});
    end
    for (int i = 1; i < 8; i++) begin
      total++;
      if ({out_valid, out_x} !== {1'b1, 9'(200 + i)}) begin
        bad++; $display("FAIL pp_drain%0d got=%h exp=%h", i, {out_valid, out_x}, {1'b1, 9'(200 + i)});
      end
      tick();
    end
    total++;
    if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'd300, 8'd77, 24'hABCDEF}) begin
      bad++; $display("FAIL pp_last got=%h exp=%h", {out_valid, out_x, out_y, out_color},
                      {1'b1, 9'd300, 8'd77, 24'hABCDEF});
    end
    tick();
  endtask

  task automatic test_clear_order();
    int sweep_bad;
    do_reset();
    for (int i = 0; i < 3; i++) push_one(9'(i + 1), 8'd50, 24'(32'h111111 * (i + 1)));
    clear_req = 1'b1; in_plot = 1'b1; in_x = 9'd400; in_y = 8'd99; in_color = 24'h777777;
    tick();
    clear_req = 1'b0; in_plot = 1'b0;
    total++;
    if ({level, busy} !== {LW'(4), 1'b1}) begin
      bad++; $display("FAIL clr_queued got=%h exp=%h", {level, busy}, {LW'(4), 1'b1});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, out_x, out_color} !== {1'b1, 9'(i + 1), 24'(32'h111111 * (i + 1))}) begin
        bad++; $display("FAIL clr_pre%0d got=%h exp=%h", i, {out_valid, out_x, out_color},
                        {1'b1, 9'(i + 1), 24'(32'h111111 * (i + 1))});
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_bubble got=%b exp=0", out_valid); end
    tick();
    sweep_bad = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        total++;
        if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'(x), 8'(y), CC}) begin
          bad++;
          if (sweep_bad < 4) $display("FAIL clr_sweep got=%h exp=%h",
                                      {out_valid, out_x, out_y, out_color}, {1'b1, 9'(x), 8'(y), CC});
          sweep_bad++;
        end
        tick();
      end
    end
    total++;
    if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'd400, 8'd99, 24'h777777}) begin
      bad++; $display("FAIL clr_post got=%h exp=%h", {out_valid, out_x, out_y, out_color},
                      {1'b1, 9'd400, 8'd99, 24'h777777});
    end
    tick(); tick(); tick();
    total++;
    if ({out_valid, busy, level} !== '0) begin
      bad++; $display("FAIL clr_done got=%h exp=0", {out_valid, busy, level});
    end
  endtask

  task automatic test_clear_stall();
    int ex, ey, npix;
    bit stalled, done;
    do_reset();
    out_ready = 1'b1; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    ex = 0; ey = 0; npix = 0; stalled = 0; done = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      out_ready = ($urandom_range(3) != 0);
      clear_req = ($urandom_range(15) == 0);
      if (out_valid && ex == W - 1 && ey == 5 && !stalled) begin
        stalled = 1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          total++;
          if ({out_valid, out_x, out_y, out_color} !== {1'b1, 9'(W - 1), 8'd5, CC}) begin
            bad++; $display("FAIL stall_hold got=%h exp=%h", {out_valid, out_x, out_y, out_color},
                            {1'b1, 9'(W - 1), 8'd5, CC});
          end
          tick();
        end
        out_ready = 1'b1;
      end
      if (out_valid) begin
        total++;
        if ({out_x, out_y, out_color} !== {9'(ex), 8'(ey), CC}) begin
          bad++; $display("FAIL stall_px got=%h exp=%h", {out_x, out_y, out_color}, {9'(ex), 8'(ey), CC});
        end
        if (out_ready) begin
          npix++;
          if (ex == W - 1) begin ex = 0; ey++; end else ex++;
          if (npix == W * H) done = 1;
        end
      end
      tick();
    end
    clear_req = 1'b0;
    total++;
    if (!(done && stalled)) begin
      bad++; $display("FAIL stall_complete got=%0d exp=%0d", npix, W * H);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_extra got=%b exp=0", out_valid); end
      tick();
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(9'(i), 8'(i), 24'(i));
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    reset_n = 1'b0;
    tick();
    total++;
    if ({out_valid, out_x, out_y, out_color, level, full, busy, overflow} !== '0) begin
      bad++; $display("FAIL midrst_state got=%h exp=0",
                      {out_valid, out_x, out_y, out_color, level, full, busy, overflow});
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({out_valid, busy} !== 2'b00) begin
        bad++; $display("FAIL midrst_quiet got=%b exp=00", {out_valid, busy});
      end
    end
  endtask

  task automatic test_random();
    int mlevel, nclr;
    bit mov, popp, clact;
    item_t it;
    do_reset();
    expq.delete();
    mlevel = 0; nclr = 0; mov = 0;
    for (int cyc = 0; cyc < 7000; cyc++) begin
      if (cyc < 4000) begin
        in_plot   = ($urandom_range(9) < 5);
        in_x      = 9'($urandom);
        in_y      = 8'($urandom);
        in_color  = 24'($urandom);
        clear_req = ($urandom_range(299) == 0);
        out_ready = ($urandom_range(3) != 0);
      end else begin
        if (expq.size() == 0) break;
        in_plot = 1'b0; clear_req = 1'b0; out_ready = 1'b1;
      end
      total++;
      if ({level, full, overflow} !== {mlevel[LW-1:0], mlevel == DEPTH, mov}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%h exp=%h", cyc, {level, full, overflow},
                        {mlevel[LW-1:0], mlevel == DEPTH, mov});
      end
      popp  = 0;
      clact = (nclr > 0);
      if (out_valid) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, {out_x, out_y, out_color});
        end else begin
          if ({out_x, out_y, out_color} !== {expq[0].x, expq[0].y, expq[0].c}) begin
            bad++; $display("FAIL rnd_px cyc=%0d got=%h exp=%h", cyc, {out_x, out_y, out_color},
                            {expq[0].x, expq[0].y, expq[0].c});
          end
          if (out_ready) begin
            if (expq[0].clr) nclr--; else popp = 1;
            void'(expq.pop_front());
          end
        end
      end
      if (clear_req && !clact) begin
        for (int yy = 0; yy < H; yy++)
          for (int xx = 0; xx < W; xx++) begin
            it.x = 9'(xx); it.y = 8'(yy); it.c = CC; it.clr = 1;
            expq.push_back(it);
          end
        nclr += W * H;
      end
      if (in_plot) begin
        if (mlevel < DEPTH || popp) begin
          it.x = in_x; it.y = in_y; it.c = in_color; it.clr = 0;
          expq.push_back(it);
          mlevel++;
        end else begin
          mov = 1;
        end
      end
      if (popp) mlevel--;
      tick();
    end
    tick(); tick();
    total++;
    if ({expq.size() == 0, level, busy, out_valid} !== {1'b1, LW'(0), 1'b0, 1'b0}) begin
      bad++; $display("FAIL rnd_drained left=%0d got=%h exp=%h", expq.size(),
                      {level, busy, out_valid}, {LW'(0), 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_pushpop_full();
    test_clear_order();
    test_clear_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
